// File: rtl/instr_encoder_loader.sv
// Program-loader path: encodes symbolic MIPS instruction requests into 32-bit words
// and writes them sequentially into instruction memory before the CPU leaves reset.
module instr_encoder_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [2:0]                   kind_i,
  input  logic                         last_i,
  input  logic [4:0]                   rs_i,
  input  logic [4:0]                   rt_i,
  input  logic [4:0]                   rd_i,
  input  logic [5:0]                   funct_i,
  input  logic [15:0]                  imm_i,
  output logic                         wr_en_o,
  output logic [31:0]                  wr_addr_o,
  output logic [31:0]                  wr_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   words_o,
  output logic                         done_o,
  output logic                         err_o
);

  // state  | meaning
  // S_IDLE | out of reset, waiting for start_i
  // S_LOAD | accepting requests, one memory write per legal request
  // S_DONE | session finished (last request seen or memory full)

  localparam int            W       = $clog2(DEPTH+1);
  localparam logic [W-1:0]  DEPTH_W = W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   words_q;
  logic           xfer;
  logic           legal;
  logic           full_next;
  logic [31:0]    enc_word;

  assign req_ready_o = (state_q == S_LOAD) && (words_q < DEPTH_W);
  assign xfer        = req_valid_i && req_ready_o;
  assign legal       = (kind_i != 3'd7);
  assign full_next   = ((words_q + W'(1)) == DEPTH_W);
  assign done_o      = (state_q == S_DONE);
  assign words_o     = words_q;

  always_comb begin
    enc_word = 32'h0;
    case (kind_i)
      3'd0:    enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
      3'd1:    enc_word = {6'b001000, rs_i, rt_i, imm_i};
      3'd2:    enc_word = {6'b000100, rs_i, rt_i, imm_i};
      3'd3:    enc_word = {6'b001011, rs_i, rt_i, imm_i};
      3'd4:    enc_word = {6'b001111, 5'b00000, rt_i, imm_i};
      3'd5:    enc_word = {6'b001101, rs_i, rt_i, imm_i};
      3'd6:    enc_word = {6'b000101, rs_i, rt_i, imm_i};
      default: enc_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      // an illegal request only ends the session when flagged last
      S_LOAD:  if (xfer && (last_i || (legal && full_next))) state_d = S_DONE;
      S_DONE:  if (start_i) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= 32'h0;
      wr_data_o <= 32'h0;
      words_q   <= '0;
      err_o     <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      err_o   <= 1'b0;
      if (xfer) begin
        if (legal) begin
          wr_en_o   <= 1'b1;
          wr_addr_o <= BASE_ADDR + (32'(words_q) << 2);
          wr_data_o <= enc_word;
          words_q   <= words_q + W'(1);
        end else begin
          err_o <= 1'b1;
        end
      end else if ((state_q != S_LOAD) && start_i) begin
        words_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: session-level model checked every cycle, plus
// directed vectors with hand-computed instruction words and addresses.
module tb_instr_encoder_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  kind = 3'd0;
  logic        last = 1'b0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic [5:0]  funct = 6'd0;
  logic [15:0] imm = 16'd0;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [2:0]  words;
  logic        done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .req_valid_i(valid),
    .req_ready_o(ready), .kind_i(kind), .last_i(last), .rs_i(rs), .rt_i(rt),
    .rd_i(rd), .funct_i(funct), .imm_i(imm), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .words_o(words),
    .done_o(done), .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] s,
                                      input logic [4:0] t, input logic [4:0] d,
                                      input logic [5:0] f, input logic [15:0] i);
    case (k)
      3'd0:    return {6'h00, s, t, d, 5'h00, f};
      3'd1:    return {6'h08, s, t, i};
      3'd2:    return {6'h04, s, t, i};
      3'd3:    return {6'h0B, s, t, i};
      3'd4:    return {6'h0F, 5'h00, t, i};
      3'd5:    return {6'h0D, s, t, i};
      3'd6:    return {6'h05, s, t, i};
      default: return 32'h0;
    endcase
  endfunction

  // Session model: a session is open or not; count words; track expected outputs.
  bit          m_init = 0;
  bit          m_open = 0;
  bit          m_done = 0;
  int          m_words = 0;
  bit          m_wr = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_data = 0;

  always @(posedge clk) begin
    bit can_take;
    m_init = 1;
    can_take = m_open && (m_words < DEPTH);
    m_wr  = 0;
    m_err = 0;
    if (!rst) begin
      m_open = 0; m_done = 0; m_words = 0; m_addr = 0; m_data = 0;
    end else if (can_take && valid) begin
      if (kind == 3'd7) begin
        m_err = 1;
        if (last) begin m_open = 0; m_done = 1; end
      end else begin
        m_wr   = 1;
        m_addr = BASE + 32'(4 * m_words);
        m_data = enc(kind, rs, rt, rd, funct, imm);
        m_words++;
        if (last || m_words == DEPTH) begin m_open = 0; m_done = 1; end
      end
    end else if (!m_open && start) begin
      m_open = 1; m_done = 0; m_words = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_ready", 32'(ready), 32'(m_open && (m_words < DEPTH)));
      chk("m_done",  32'(done),  32'(m_done));
      chk("m_words", 32'(words), 32'(m_words));
      chk("m_wr_en", 32'(wr_en), 32'(m_wr));
      chk("m_err",   32'(err),   32'(m_err));
      chk("m_addr",  wr_addr,    m_addr);
      chk("m_data",  wr_data,    m_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                      input logic l);
    kind = k; rs = s; rt = t; rd = d; funct = f; imm = i; last = l; valid = 1'b1;
    cyc();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  int n_wr;
  logic [31:0] last_wr_addr;

  initial begin
    repeat (2) cyc();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr",  wr_addr, 0);
    chk("rst_data",  wr_data, 0);
    chk("rst_words", 32'(words), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    rst = 1'b1;
    cyc();
    start_pulse();
    chk("start_ready", 32'(ready), 1);

    send(3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 1'b0);
    chk("addi_wr_en", 32'(wr_en), 1);
    chk("addi_data", wr_data, 32'h20220005);
    chk("addi_addr", wr_addr, 32'h40);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 1'b1);
    chk("r_data",  wr_data, 32'h00221820);
    chk("r_addr",  wr_addr, 32'h44);
    chk("r_words", 32'(words), 2);
    chk("r_done",  32'(done), 1);
    chk("r_ready", 32'(ready), 0);
    cyc();
    chk("r_after_wr_en", 32'(wr_en), 0);

    start_pulse();
    chk("restart_words", 32'(words), 0);
    chk("restart_done",  32'(done), 0);
    send(3'd4, 5'h1F, 5'h0A, 5'd0, 6'h00, 16'hBEEF, 1'b0);
    chk("lui_data", wr_data, 32'h3C0ABEEF);
    chk("lui_addr", wr_addr, 32'h40);
    send(3'd5, 5'h1F, 5'h0A, 5'd0, 6'h00, 16'hBEEF, 1'b0);
    chk("ori_data", wr_data, 32'h37EABEEF);
    send(3'd3, 5'h1F, 5'h0A, 5'd0, 6'h00, 16'hBEEF, 1'b0);
    chk("sltiu_data", wr_data, 32'h2FEABEEF);
    send(3'd2, 5'h1F, 5'h0A, 5'd0, 6'h00, 16'hBEEF, 1'b0);
    chk("beq_data",   wr_data, 32'h13EABEEF);
    chk("beq_addr",   wr_addr, 32'h4C);
    chk("full_done",  32'(done), 1);
    chk("full_ready", 32'(ready), 0);

    start_pulse();
    send(3'd6, 5'h1F, 5'h0A, 5'd0, 6'h00, 16'hBEEF, 1'b0);
    chk("bne_data", wr_data, 32'h17EABEEF);
    chk("bne_addr", wr_addr, 32'h40);
    start_pulse();
    chk("start_in_load_words", 32'(words), 1);
    send(3'd7, 5'd3, 5'd4, 5'd5, 6'h01, 16'h1234, 1'b0);
    chk("ill_err",   32'(err), 1);
    chk("ill_wr_en", 32'(wr_en), 0);
    chk("ill_words", 32'(words), 1);
    chk("ill_data",  wr_data, 32'h17EABEEF);
    cyc();
    chk("ill_err_pulse", 32'(err), 0);
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 1'b0);
    chk("post_ill_addr", wr_addr, 32'h44);
    chk("post_ill_words", 32'(words), 2);
    send(3'd7, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 1'b1);
    chk("ill_last_done", 32'(done), 1);
    chk("ill_last_words", 32'(words), 2);

    start_pulse();
    n_wr = 0;
    last_wr_addr = 32'h0;
    kind = 3'd1; rs = 5'd2; rt = 5'd3; last = 1'b0; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imm = 16'(i);
      cyc();
      if (wr_en) begin n_wr++; last_wr_addr = wr_addr; end
    end
    valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      if (wr_en) n_wr++;
    end
    chk("stream_writes", 32'(n_wr), 4);
    chk("stream_last_addr", last_wr_addr, 32'h4C);
    chk("stream_last_data", wr_data, 32'h20430003);
    chk("stream_done", 32'(done), 1);

    start_pulse();
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 1'b0);
    kind = 3'd5; rs = 5'd6; rt = 5'd7; imm = 16'h00FF; valid = 1'b1; rst = 1'b0;
    cyc();
    valid = 1'b0;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_addr",  wr_addr, 0);
    chk("mid_rst_data",  wr_data, 0);
    chk("mid_rst_words", 32'(words), 0);
    chk("mid_rst_ready", 32'(ready), 0);
    rst = 1'b1;
    cyc();
    chk("post_rst_wr_en", 32'(wr_en), 0);
    start_pulse();
    send(3'd5, 5'd6, 5'd7, 5'd0, 6'h00, 16'h00FF, 1'b1);
    chk("after_rst_addr", wr_addr, 32'h40);
    chk("after_rst_data", wr_data, 32'h34C700FF);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
